// File: rtl/speaker_pwm_output_if.sv
// Sample-input handshake bundle for the speaker PWM output stage.
// The master drives complex sample words; the slave returns in_ready.
interface speaker_pwm_output_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] input_stream;
  logic             in_valid;
  logic             in_ready;

  modport master (output input_stream, output in_valid, input in_ready);
  modport slave  (input input_stream, input in_valid, output in_ready);
endinterface

// File: rtl/speaker_pwm_output.sv
// Speaker PWM output: FIFO of saturated duty values, one sample per PWM period.
// Optional macro UNDERRUN_MIDSCALE_EN: on underrun play midscale instead of repeating the last duty.
module speaker_pwm_output #(
  parameter int WIDTH      = 32,
  parameter int PWM_BITS   = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  speaker_pwm_output_if.slave           in_if,
  output logic                          pwm_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);

  localparam int HALF = WIDTH / 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;

  localparam logic [PWM_BITS-1:0]    CNT_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0]    MIDSCALE = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic signed [HALF-1:0] SAT_HI   = HALF'((32'sd1 <<< (PWM_BITS-1)) - 32'sd1);
  localparam logic signed [HALF-1:0] SAT_LO   = ~SAT_HI;
  localparam logic [LW-1:0]          LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]          LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]          PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  // Clamp to the PWM range, then flipping the sign bit adds the midscale offset.
  function automatic logic [PWM_BITS-1:0] to_duty(input logic signed [HALF-1:0] r);
    if (r > SAT_HI) begin
      return {PWM_BITS{1'b1}};
    end else if (r < SAT_LO) begin
      return {PWM_BITS{1'b0}};
    end else begin
      return {~r[PWM_BITS-1], r[PWM_BITS-2:0]};
    end
  endfunction

  logic [PWM_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;
  logic [LW-1:0]       level_q, level_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                underrun_q, underrun_d;

  logic push_s, pop_s, boundary_s, full_s, empty_s;
  logic unused_imag_s;

  assign unused_imag_s = ^in_if.input_stream[WIDTH-1:HALF];

  assign full_s     = (level_q == LVL_FULL);
  assign empty_s    = (level_q == {LW{1'b0}});
  assign boundary_s = (cnt_q == CNT_MAX);
  assign push_s     = in_if.in_valid && !full_s;
  assign pop_s      = boundary_s && !empty_s;

  assign in_if.in_ready = !full_s;
  assign pwm_out        = pwm_q;
  assign fifo_level     = level_q;
  assign underrun       = underrun_q;

  // Next-state logic for the PWM engine, FIFO bookkeeping and underrun flag.
  always_comb begin
    cnt_d      = cnt_q + {{(PWM_BITS-1){1'b0}}, 1'b1};
    pwm_d      = (cnt_q < duty_q);
    duty_d     = duty_q;
    level_d    = level_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    underrun_d = underrun_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      duty_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else if (boundary_s) begin
      underrun_d = 1'b1;
`ifdef UNDERRUN_MIDSCALE_EN
      duty_d     = MIDSCALE;
`else
      duty_d     = duty_q;
`endif
    end else begin
      duty_d   = duty_q;
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // State registers with asynchronous flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= {PWM_BITS{1'b0}};
      duty_q     <= MIDSCALE;
      pwm_q      <= 1'b0;
      level_q    <= {LW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      underrun_q <= underrun_d;
    end
  end

  // Sample storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= to_duty($signed(in_if.input_stream[HALF-1:0]));
    end
  end

endmodule

// File: tb/tb_speaker_pwm_output.sv
// Directed bench for speaker_pwm_output (WIDTH=32, PWM_BITS=4, FIFO_DEPTH=4).
// A queue-based period model is compared every cycle; literal period counts pin the model.
module tb_speaker_pwm_output;

  localparam int W = 32;
  localparam int P = 4;
  localparam int D = 4;
  localparam int PERIOD = 16;

  logic       clk;
  logic       reset;
  logic       pwm_out;
  logic [2:0] fifo_level;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  speaker_pwm_output_if #(.WIDTH(W)) bus ();

  speaker_pwm_output #(.WIDTH(W), .PWM_BITS(P), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (bus),
    .pwm_out    (pwm_out),
    .fifo_level (fifo_level),
    .underrun   (underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: position within the period, queue of pending duties, active duty.
  int m_cnt   = 0;
  int m_duty  = 8;
  int m_pwm   = 0;
  int m_under = 0;
  int q[$];

  function automatic int model_duty(input logic [31:0] w);
    int r;
    r = int'($signed(w[15:0]));
    if (r > 7) r = 7;
    if (r < -8) r = -8;
    return r + 8;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_duty = 8; m_pwm = 0; m_under = 0;
      q.delete();
    end else begin
      bit do_push;
      m_pwm = (m_cnt < m_duty) ? 1 : 0;
      do_push = bus.in_valid && (q.size() < D);
      if (m_cnt == PERIOD - 1) begin
        if (q.size() > 0) begin
          m_duty = q.pop_front();
        end else begin
          m_under = 1;
`ifdef UNDERRUN_MIDSCALE_EN
          m_duty = 8;
`endif
        end
      end
      if (do_push) q.push_back(model_duty(bus.input_stream));
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("pwm_out", int'(pwm_out), m_pwm);
    check("fifo_level", int'(fifo_level), q.size());
    check("in_ready", int'(bus.in_ready), (q.size() < D) ? 1 : 0);
    check("underrun", int'(underrun), m_under);
  end

  // Count high cycles over the next full period, starting at cnt=0.
  task automatic measure(input string name, input int exp);
    int h, g;
    g = 0;
    @(negedge clk);
    while (m_cnt != 1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) check({name, "_align_timeout"}, 0, 1);
    h = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      h += int'(pwm_out);
    end
    check(name, h, exp);
  endtask

  task automatic push_one(input logic [31:0] w);
    bus.input_stream = w;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] fill_v [5];

  initial begin
    int vi, g;
    logic rdy, rdy_prev;
    fill_v[0] = 32'h0000_0001; fill_v[1] = 32'h0000_0002; fill_v[2] = 32'h1234_0003;
    fill_v[3] = 32'h0000_0004; fill_v[4] = 32'h0000_0005;
    bus.input_stream = 32'h0;
    bus.in_valid = 1'b0;
    reset = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_ready", int'(bus.in_ready), 1);
    check("reset_level", int'(fifo_level), 0);
    check("reset_underrun", int'(underrun), 0);
    reset = 1'b0;

    measure("idle_midscale_high", 8);
    check("underrun_after_boundary", int'(underrun), 1);

    push_one(32'hABCD_0003);
    check("level_after_push", int'(fifo_level), 1);
    measure("real3_high", 11);
    check("level_after_pop", int'(fifo_level), 0);

    push_one(32'h0000_7FFF);
    measure("sat_pos_high", 15);
    push_one(32'h0000_8000);
    measure("sat_neg_high", 0);
    push_one(32'h0000_FFFF);
    measure("minus1_high", 7);

    // Hold in_valid high through a full FIFO.
    vi = 0; g = 0; rdy_prev = 1'b1;
    bus.input_stream = fill_v[0];
    bus.in_valid = 1'b1;
    while (vi < 5 && g < 64) begin
      rdy = bus.in_ready;
      if (!rdy_prev && rdy) begin
        check("level_after_full_pop", int'(fifo_level), 3);
      end
      rdy_prev = rdy;
      @(negedge clk);
      g++;
      if (rdy) begin
        vi++;
        if (vi == 4) begin
          check("level_full", int'(fifo_level), 4);
          check("ready_full", int'(bus.in_ready), 0);
        end
        if (vi < 5) bus.input_stream = fill_v[vi];
      end
    end
    bus.in_valid = 1'b0;
    if (g >= 64) check("fill_timeout", 0, 1);
    check("level_after_fifth", int'(fifo_level), 4);

    measure("fill2_high", 10);
    measure("fill3_high", 11);
    measure("fill4_high", 12);
    measure("fill5_high", 13);
`ifdef UNDERRUN_MIDSCALE_EN
    measure("underrun_period_high", 8);
`else
    measure("underrun_period_high", 13);
`endif
    check("underrun_sticky", int'(underrun), 1);

    // Reset mid-period with two samples queued.
    bus.input_stream = 32'h0000_0003;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.input_stream = 32'h0000_0005;
    @(negedge clk);
    bus.in_valid = 1'b0;
    g = 0;
    while (m_cnt != 6 && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) check("cnt6_timeout", 0, 1);
    check("level_before_reset", int'(fifo_level), 2);
    #2 reset = 1'b1;
    #1;
    check("async_pwm", int'(pwm_out), 0);
    check("async_level", int'(fifo_level), 0);
    check("async_underrun", int'(underrun), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    measure("post_reset_midscale", 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
